sequence_player: RTL

//  FPGA-side "transmitter" of the memory game: plays the stored colour sequence to the player.

---
 rtl/sequence_player.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sequence_player.sv
// Memory-game LED sequence player: shows each stored colour for a lit
// interval followed by a dark gap, then flags completion on end_FPGA.
//
// Ports:
//   CLOCK_50  system clock
//   reset     synchronous active-high reset
//   start     play request (accepted only in IDLE or DONE)
//   abort     synchronous return to IDLE
//   round     number of steps to play (clamped to MAX_LEN)
//   seq       packed 2-bit symbols, step i = seq[2*i+1:2*i]
//   leds      one-hot LED drive for the current symbol, 0 when dark
//   busy      high while a sequence is being shown
//   end_FPGA  high once the whole sequence has been shown
//   step_idx  index of the step currently being shown
module sequence_player #(
  parameter int ON_TICKS  = 25_000_000,
  parameter int OFF_TICKS = 12_500_000,
  parameter int MAX_LEN   = 16
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [4:0]           round,
  input  logic [2*MAX_LEN-1:0] seq,
  output logic [3:0]           leds,
  output logic                 busy,
  output logic                 end_FPGA,
  output logic [4:0]           step_idx
);

  localparam int MAXT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [CW-1:0] ON_LAST  = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_TICKS - 1);
  localparam logic [4:0]    MAXL     = 5'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4:0]           idx_q, idx_d;
  logic [4:0]           len_q, len_d;
  logic [2*MAX_LEN-1:0] seq_q, seq_d;

  logic [4:0] rlen;
  logic [1:0] sym;

  assign rlen = (round > MAXL) ? MAXL : round;
  assign sym  = seq_q[{idx_q, 1'b0} +: 2];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      seq_q   <= seq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    seq_d   = seq_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          seq_d   = seq;
          len_d   = rlen;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = (rlen == 5'd0) ? S_DONE : S_ON;
        end
      end
      S_ON: begin
        if (cnt_q == ON_LAST) begin
          cnt_d   = '0;
          state_d = S_OFF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OFF: begin
        if (cnt_q == OFF_LAST) begin
          cnt_d = '0;
          if (idx_q == len_q - 5'd1) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_ON;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // abort beats any start seen in the same cycle
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  assign leds     = (state_q == S_ON) ? (4'b0001 << sym) : 4'b0000;
  assign busy     = (state_q == S_ON) || (state_q == S_OFF);
  assign end_FPGA = (state_q == S_DONE);
  assign step_idx = idx_q;

endmodule
